// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared definitions for the memory-mapped user-I/O peripheral:
//               register offsets inside the 0x8000_00xx window, status-word
//               bit positions and the status-word packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Byte offsets inside the I/O window (io_addr = addr[7:0]).
    localparam logic [7:0] MMIO_CYC      = 8'h10;
    localparam logic [7:0] MMIO_INST     = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST  = 8'h18;
    localparam logic [7:0] MMIO_BTN_STAT = 8'h20;
    localparam logic [7:0] MMIO_BTN_DATA = 8'h24;
    localparam logic [7:0] MMIO_SW       = 8'h28;
    localparam logic [7:0] MMIO_LED      = 8'h30;
    localparam logic [7:0] MMIO_EVT_BASE = 8'h40;

    // Button-FIFO status word bit positions.
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    // Status word: {count[31:8], 5'b0, ovf, full, empty}.
    function automatic logic [31:0] status_word(input logic [23:0] cnt,
                                                input logic        ovf,
                                                input logic        full,
                                                input logic        empty);
        logic [31:0] w;
        w                = '0;
        w[31:STAT_CNT_LSB] = cnt;
        w[STAT_OVF]      = ovf;
        w[STAT_FULL]     = full;
        w[STAT_EMPTY]    = empty;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmio_sync_fifo
// Description : Single-clock FIFO with first-word-fall-through head output.
//               A push while full is accepted only if a pop happens in the
//               same cycle; a pop while empty is ignored.
// Ports       : clk, rst_n (async, active-low), push, pop, din -> dout (head),
//               empty, full, count (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8               // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    // When full, the slot being written is the head being popped this cycle;
    // the head is read combinationally before the edge, so order is kept.
    assign push_ok = push && (!full || pop_ok);

    // Storage carries no reset: only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmio_io_ctrl
// Description : Memory-mapped user-I/O and performance-counter peripheral for
//               the Riscv151 data bus (0x8000_00xx window). Cycle/instruction
//               counters, button rising-edge FIFO with sticky overflow,
//               switch readback, LED register, optional event counters.
// Config      : define MMIO_EVT_CNT_EN to build NUM_EVT event counters at
//               0x40 + 4*i; otherwise those reads return 0 and evt_in is unused.
// Ports       : clk, rst_n (async, active-low); bus io_addr/io_sel/io_re/io_we/
//               io_wdata -> io_rdata (registered, 1-cycle latency);
//               inst_retire, evt_in, clean_buttons, switches -> leds
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter int NUM_BTN = 3,
    parameter int NUM_SW  = 2,
    parameter int NUM_LED = 6,
    parameter int FIFO_D  = 8,
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         io_addr,
    input  logic               io_sel,
    input  logic               io_re,
    input  logic               io_we,
    input  logic [31:0]        io_wdata,
    output logic [31:0]        io_rdata,
    input  logic               inst_retire,
    input  logic [NUM_EVT-1:0] evt_in,
    input  logic [NUM_BTN-1:0] clean_buttons,
    input  logic [NUM_SW-1:0]  switches,
    output logic [NUM_LED-1:0] leds
);

    localparam int CW = $clog2(FIFO_D) + 1;

    logic               rd_req, wr_req, cnt_clr, stat_wr, led_wr;
    logic [CNT_W-1:0]   cycle_q, cycle_d, inst_q, inst_d;
    logic [NUM_BTN-1:0] btn_q, rise;
    logic               push, pop_fire;
    logic [NUM_BTN-1:0] fifo_dout;
    logic               fifo_empty, fifo_full;
    logic [CW-1:0]      fifo_count;
    logic               ovf_q, ovf_d;
    logic [NUM_LED-1:0] leds_q;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0][31:0]   evt_rd;
    logic               unused_wdata;

    assign rd_req   = io_sel && io_re;
    assign wr_req   = io_sel && io_we;
    assign cnt_clr  = wr_req && (io_addr == MMIO_CNT_RST);
    assign stat_wr  = wr_req && (io_addr == MMIO_BTN_STAT);
    assign led_wr   = wr_req && (io_addr == MMIO_LED);

    assign rise     = clean_buttons & ~btn_q;
    assign push     = |rise;
    assign pop_fire = rd_req && (io_addr == MMIO_BTN_DATA) && !fifo_empty;

    assign unused_wdata = ^io_wdata;

    mmio_sync_fifo #(
        .WIDTH (NUM_BTN),
        .DEPTH (FIFO_D)
    ) u_btn_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop_fire),
        .din   (rise),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // A clear store discards that cycle's increments.
    always_comb begin
        cycle_d = cnt_clr ? '0 : cycle_q + 1'b1;
        inst_d  = cnt_clr ? '0 : inst_q + {{(CNT_W-1){1'b0}}, inst_retire};
    end

    // Overflow set has priority over a same-cycle clearing store.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_wr)                          ovf_d = 1'b0;
        if (push && fifo_full && !pop_fire)   ovf_d = 1'b1;
    end

`ifdef MMIO_EVT_CNT_EN
    for (genvar i = 0; i < 8; i++) begin : g_evt
        if (i < NUM_EVT) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)           cnt_q <= '0;
                else if (cnt_clr)     cnt_q <= '0;
                else if (evt_in[i])   cnt_q <= cnt_q + 1'b1;
            end
            assign evt_rd[i] = 32'(cnt_q);
        end else begin : g_none
            assign evt_rd[i] = '0;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = ^evt_in;
    assign evt_rd     = '0;
`endif

    // Status reflects state before any same-cycle push/pop.
    always_comb begin
        rdata_d = '0;
        case (io_addr)
            MMIO_CYC:      rdata_d = 32'(cycle_q);
            MMIO_INST:     rdata_d = 32'(inst_q);
            MMIO_BTN_STAT: rdata_d = status_word(24'(fifo_count), ovf_q,
                                                 fifo_full, fifo_empty);
            MMIO_BTN_DATA: rdata_d = fifo_empty ? '0 : 32'(fifo_dout);
            MMIO_SW:       rdata_d = 32'(switches);
            MMIO_LED:      rdata_d = 32'(leds_q);
            default: begin
                // 0x40..0x5C: event counter window, 8 word slots.
                if (io_addr[7:5] == MMIO_EVT_BASE[7:5]) begin
                    rdata_d = evt_rd[io_addr[4:2]];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            inst_q  <= '0;
            btn_q   <= '0;
            ovf_q   <= 1'b0;
            leds_q  <= '0;
            rdata_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            inst_q  <= inst_d;
            btn_q   <= clean_buttons;
            ovf_q   <= ovf_d;
            if (led_wr) leds_q  <= io_wdata[NUM_LED-1:0];
            if (rd_req) rdata_q <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;
    assign leds     = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_io_ctrl
// Description : Self-checking bench for mmio_io_ctrl. Directed scenarios plus
//               randomized bus/button/event traffic, all compared every cycle
//               against a queue-based behavioural model of the peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_io_ctrl;

    localparam int NUM_BTN = 3;
    localparam int NUM_SW  = 2;
    localparam int NUM_LED = 6;
    localparam int FIFO_D  = 8;
    localparam int CNT_W   = 32;
    localparam int NUM_EVT = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         io_addr = '0;
    logic               io_sel = 1'b0, io_re = 1'b0, io_we = 1'b0;
    logic [31:0]        io_wdata = '0;
    logic [31:0]        io_rdata;
    logic               inst_retire = 1'b0;
    logic [NUM_EVT-1:0] evt_in = '0;
    logic [NUM_BTN-1:0] clean_buttons = '0;
    logic [NUM_SW-1:0]  switches = '0;
    logic [NUM_LED-1:0] leds;

    mmio_io_ctrl #(
        .NUM_BTN (NUM_BTN), .NUM_SW (NUM_SW), .NUM_LED (NUM_LED),
        .FIFO_D  (FIFO_D),  .CNT_W  (CNT_W),  .NUM_EVT (NUM_EVT)
    ) dut (
        .clk (clk), .rst_n (rst_n), .io_addr (io_addr), .io_sel (io_sel),
        .io_re (io_re), .io_we (io_we), .io_wdata (io_wdata),
        .io_rdata (io_rdata), .inst_retire (inst_retire), .evt_in (evt_in),
        .clean_buttons (clean_buttons), .switches (switches), .leds (leds)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]        m_cyc, m_inst, m_rdata;
    logic [31:0]        m_evt [NUM_EVT];
    logic [NUM_BTN-1:0] m_prev;
    logic [NUM_LED-1:0] m_leds;
    logic               m_ovf;
    logic [NUM_BTN-1:0] m_q [$];

    task automatic model_reset();
        m_cyc = 0; m_inst = 0; m_rdata = 0; m_prev = 0; m_leds = 0; m_ovf = 0;
        for (int i = 0; i < NUM_EVT; i++) m_evt[i] = 0;
        m_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] v;
        int n;
        v = 0;
        n = m_q.size();
        case (a)
            8'h10: v = m_cyc;
            8'h14: v = m_inst;
            8'h20: v = (32'(n) << 8) + (m_ovf ? 4 : 0) + (n == FIFO_D ? 2 : 0) + (n == 0 ? 1 : 0);
            8'h24: v = (n > 0) ? 32'(m_q[0]) : 32'd0;
            8'h28: v = 32'(switches);
            8'h30: v = 32'(m_leds);
            default: if (a >= 8'h40 && int'(a) < 'h40 + 4 * NUM_EVT) v = m_evt[(int'(a) - 'h40) / 4];
        endcase
        return v;
    endfunction

    task automatic model_step();
        logic rd, wr, pop, full_pre;
        logic [31:0] rv;
        logic [NUM_BTN-1:0] rise;
        rd       = io_sel && io_re;
        wr       = io_sel && io_we;
        rv       = model_read(io_addr);
        pop      = rd && io_addr == 8'h24 && m_q.size() > 0;
        full_pre = (m_q.size() == FIFO_D);
        rise     = clean_buttons & ~m_prev;
        if (pop) void'(m_q.pop_front());
        if (rise != 0) begin
            if (!full_pre || pop) m_q.push_back(rise);
            else                  m_ovf = 1;
        end
        if (rise != 0 && full_pre && !pop) m_ovf = 1;
        else if (wr && io_addr == 8'h20)   m_ovf = 0;
        m_prev = clean_buttons;
        if (wr && io_addr == 8'h18) begin
            m_cyc = 0; m_inst = 0;
            for (int i = 0; i < NUM_EVT; i++) m_evt[i] = 0;
        end else begin
            m_cyc  = m_cyc + 1;
            m_inst = m_inst + 32'(inst_retire);
`ifdef MMIO_EVT_CNT_EN
            for (int i = 0; i < NUM_EVT; i++) m_evt[i] = m_evt[i] + 32'(evt_in[i]);
`endif
        end
        if (wr && io_addr == 8'h30) m_leds = io_wdata[NUM_LED-1:0];
        if (rd) m_rdata = rv;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("rdata", io_rdata, m_rdata);
        chk("leds", 32'(leds), 32'(m_leds));
    endtask

    task automatic idle_bus();
        io_sel = 0; io_re = 0; io_we = 0;
    endtask

    task automatic load(input logic [7:0] a);
        io_sel = 1; io_re = 1; io_we = 0; io_addr = a;
        tick();
        idle_bus();
    endtask

    task automatic store(input logic [7:0] a, input logic [31:0] d);
        io_sel = 1; io_re = 0; io_we = 1; io_addr = a; io_wdata = d;
        tick();
        idle_bus();
    endtask

    logic [NUM_BTN-1:0] pat [9];
    logic [7:0]         addr_tab [13];
    logic [31:0]        exp_evt;

    initial begin
        pat      = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        addr_tab = '{8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h24, 8'h28, 8'h30,
                     8'h40, 8'h44, 8'h48, 8'h3C, 8'h00};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", io_rdata, 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        rst_n = 1;

        // 1: 23 idle cycles, inst_retire high for 21 of them
        inst_retire = 1;
        repeat (21) tick();
        inst_retire = 0;
        repeat (2) tick();
        load(8'h10); chk("cyc_23", io_rdata, 32'd23);
        load(8'h14); chk("inst_21", io_rdata, 32'd21);

        // 2: clear store discards same-cycle increment
        inst_retire = 1;
        store(8'h18, 32'hDEAD_BEEF);
        inst_retire = 0;
        load(8'h10); chk("cyc_clr", io_rdata, 32'd0);
        load(8'h10); chk("cyc_after", io_rdata, 32'd1);
        load(8'h14); chk("inst_clr", io_rdata, 32'd0);

        // 3: single rising event
        clean_buttons = 3'b111;
        tick();
        load(8'h20); chk("stat_one", io_rdata, 32'h100);
        load(8'h24); chk("pop_7", io_rdata, 32'h7);
        load(8'h20); chk("stat_empty", io_rdata, 32'h1);
        load(8'h24); chk("pop_empty", io_rdata, 32'h0);

        // 4: nine events into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            clean_buttons = 0;      tick();
            clean_buttons = pat[i]; tick();
        end
        load(8'h20); chk("stat_ovf", io_rdata, 32'h806);
        store(8'h20, 32'h0);
        load(8'h20); chk("stat_ovf_clr", io_rdata, 32'h802);
        for (int i = 0; i < 8; i++) begin
            load(8'h24); chk("pop_order", io_rdata, 32'(pat[i]));
        end
        load(8'h20); chk("stat_drained", io_rdata, 32'h1);

        // 5: push and pop together while full
        for (int i = 0; i < 8; i++) begin
            clean_buttons = 0;      tick();
            clean_buttons = pat[i]; tick();
        end
        clean_buttons = 0; tick();
        clean_buttons = 3'b101;
        load(8'h24); chk("full_pushpop", io_rdata, 32'(pat[0]));
        load(8'h20); chk("stat_full_kept", io_rdata, 32'h802);

        // 6: switches, LEDs, event counter, unmapped
        switches = 2'b11;
        load(8'h28); chk("switches", io_rdata, 32'h3);
        store(8'h30, 32'hFFFF_FFFF);
        chk("leds_set", 32'(leds), 32'h3F);
        load(8'h30); chk("leds_read", io_rdata, 32'h3F);
        for (int i = 0; i < 5; i++) begin
            evt_in = 4'b0100; tick();
            evt_in = 0;       tick();
        end
`ifdef MMIO_EVT_CNT_EN
        exp_evt = 32'd5;
`else
        exp_evt = 32'd0;
`endif
        load(8'h48); chk("evt2", io_rdata, exp_evt);
        load(8'h60); chk("unmapped", io_rdata, 32'h0);

        // Asynchronous reset in the middle of a cycle
        load(8'h30);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_rdata", io_rdata, 32'h0);
        chk("arst_leds", 32'(leds), 32'h0);
        model_reset();
        m_prev = clean_buttons;   // held buttons are not a rising edge after reset...
        m_prev = 0;               // ...but history clears, so a held button re-rises
        @(negedge clk);
        rst_n = 1;
        clean_buttons = 0;
        load(8'h20); chk("arst_stat", io_rdata, 32'h1);
        load(8'h10); chk("arst_cyc", io_rdata, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            r             = int'($urandom_range(0, 9));
            io_sel        = ($urandom_range(0, 3) != 0);
            io_re         = (r < 5);
            io_we         = (r >= 5 && r < 7);
            io_addr       = addr_tab[$urandom_range(0, 12)];
            if (io_addr == 8'h18 && $urandom_range(0, 3) != 0) io_we = 0;
            io_wdata      = $urandom;
            clean_buttons = NUM_BTN'($urandom);
            switches      = NUM_SW'($urandom);
            inst_retire   = 1'($urandom);
            evt_in        = NUM_EVT'($urandom);
            tick();
        end
        idle_bus();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
